// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and saturation helpers for addsub_seq
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_W = 64;

    // Largest positive value of a w-bit two's complement number: 0 then w-1 ones.
    function automatic logic [MAX_W-1:0] sat_pos(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] sat_neg(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] sat_value(input logic neg, input int w);
        return neg ? sat_neg(w) : sat_pos(w);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - W-bit combinational adder slice with carry into and out of its MSB
module add_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] full;

    assign full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    assign s    = full[W-1:0];
    assign cout = full[W];
    // The MSB sum bit is x^y^carry_in, so the carry into the MSB falls out by XOR.
    assign cmsb = full[W-1] ^ x[W-1] ^ y[W-1];

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - chunk-serial two's complement adder/subtractor with optional saturation
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, b_q, psum_q, result_q;
    logic             cin_q, sat_q, done_q, carry_q, ovf_q;

    logic             load, last;
    int               base;
    logic [CHUNK-1:0] x, y, s;
    logic             cout, cmsb, raw_ovf;
    logic [WIDTH-1:0] full_sum, final_res;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = (state_q == CALC) && (cnt_q == CW'(N - 1));
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) cnt_d = '0;
    end

    always_comb begin
        base      = int'(cnt_q) * CHUNK;
        x         = a_q[base +: CHUNK];
        y         = b_q[base +: CHUNK];
        full_sum  = psum_q;
        full_sum[base +: CHUNK] = s;
        raw_ovf   = cmsb ^ cout;
        // Saturation direction follows a's sign: overflow only occurs when both
        // effective operands share that sign.
        final_res = (sat_q && raw_ovf) ? WIDTH'(sat_value(a_q[WIDTH-1], WIDTH)) : full_sum;
    end

    add_chunk #(.W(CHUNK)) u_add_chunk (
        .x    (x),
        .y    (y),
        .cin  (cin_q),
        .s    (s),
        .cout (cout),
        .cmsb (cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            psum_q   <= '0;
            cin_q    <= 1'b0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= last;
            if (load) begin
                a_q   <= a;
                b_q   <= sub ? ~b : b;
                cin_q <= sub;
                sat_q <= sat;
            end else if (state_q == CALC) begin
                psum_q <= full_sum;
                cin_q  <= cout;
                if (last) begin
                    result_q <= final_res;
                    carry_q  <= cout;
                    ovf_q    <= raw_ovf;
                end
            end
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - scoreboard bench for addsub_seq (16/4 and 8/8 configurations)
module tb_addsub_seq;

    localparam int N16 = 4;
    localparam int N8  = 1;

    typedef struct {
        logic [31:0] res;
        logic        carry;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, sub = 1'b0, sat = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, carry, ovf;
    logic [15:0] result;

    logic        start8 = 1'b0, sub8 = 1'b0, sat8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, carry8, ovf8;
    logic [7:0]  result8;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q16[$];
    exp_t q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub), .sat(sat),
        .busy(busy), .done(done), .result(result), .carry(carry), .ovf(ovf)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8), .sat(sat8),
        .busy(busy8), .done(done8), .result(result8), .carry(carry8), .ovf(ovf8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Reference: signed arithmetic on the true values, then wrap or clamp.
    function automatic exp_t model(input int w, input longint ua, input longint ub,
                                   input bit s, input bit st);
        exp_t   e;
        longint m, sa, sb, tot, hi, lo;
        m   = longint'(1) << w;
        hi  = m / 2 - 1;
        lo  = -(m / 2);
        sa  = (ua > hi) ? ua - m : ua;
        sb  = (ub > hi) ? ub - m : ub;
        tot = s ? sa - sb : sa + sb;
        e.ovf   = (tot > hi) || (tot < lo);
        e.carry = s ? (ua >= ub) : (ua + ub >= m);
        if (st && e.ovf) tot = (tot > hi) ? hi : lo;
        e.res = 32'(tot & (m - 1));
        e.due = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (q16.size() == 0) chk("d16_unexpected_done", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q16.pop_front();
                    chk("d16_result", {16'h0, result}, e.res);
                    chk("d16_carry", {31'h0, carry}, {31'h0, e.carry});
                    chk("d16_ovf", {31'h0, ovf}, {31'h0, e.ovf});
                    chk("d16_latency", cyc, e.due);
                end
            end else if (q16.size() > 0 && cyc > q16[0].due) begin
                chk("d16_missing_done", 32'd0, 32'd1);
                void'(q16.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done8) begin
                if (q8.size() == 0) chk("d8_unexpected_done", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("d8_result", {24'h0, result8}, e.res);
                    chk("d8_carry", {31'h0, carry8}, {31'h0, e.carry});
                    chk("d8_ovf", {31'h0, ovf8}, {31'h0, e.ovf});
                    chk("d8_latency", cyc, e.due);
                end
            end else if (q8.size() > 0 && cyc > q8[0].due) begin
                chk("d8_missing_done", 32'd0, 32'd1);
                void'(q8.pop_front());
            end
        end
    end

    task automatic issue16(input logic [15:0] ta, input logic [15:0] tb_, input bit ts, input bit tsat);
        exp_t e;
        e = model(16, longint'(ta), longint'(tb_), ts, tsat);
        e.due = cyc + 1 + N16;
        a = ta; b = tb_; sub = ts; sat = tsat; start = 1'b1;
        q16.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); sat = 1'($urandom);
    endtask

    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_, input bit ts, input bit tsat);
        exp_t e;
        e = model(8, longint'(ta), longint'(tb_), ts, tsat);
        e.due = cyc + 1 + N8;
        a8 = ta; b8 = tb_; sub8 = ts; sat8 = tsat; start8 = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic wait_done16();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("d16_wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done8();
        int n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) chk("d8_wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (q16.size() != 0 || q8.size() != 0) chk("queue_drain_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_result", {16'h0, result}, 32'd0);
        chk("rst_carry", {31'h0, carry}, 32'd0);
        chk("rst_ovf", {31'h0, ovf}, 32'd0);
        chk("rst_busy8", {31'h0, busy8}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue16(16'h1234, 16'h1111, 1'b0, 1'b0);
        for (int i = 0; i < N16; i++) begin
            chk("busy_during_calc", {31'h0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("busy_after_calc", {31'h0, busy}, 32'd0);
        chk("done_at_latency", {31'h0, done}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'h0, done}, 32'd0);
        chk("result_held", {16'h0, result}, 32'h2345);

        issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_idle();
        issue16(16'h7FFF, 16'h0001, 1'b0, 1'b1); wait_idle();
        issue16(16'h8000, 16'h0001, 1'b1, 1'b0); wait_idle();
        issue16(16'h8000, 16'h0001, 1'b1, 1'b1); wait_idle();
        issue16(16'h0005, 16'h0007, 1'b1, 1'b0); wait_idle();

        // start again while busy: must be ignored
        issue16(16'h0102, 16'h0304, 1'b0, 1'b0);
        a = 16'hFFFF; b = 16'h7FFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // back-to-back: new start during the DONE cycle
        issue16(16'h4000, 16'h4000, 1'b0, 1'b1);
        wait_done16();
        issue16(16'hC000, 16'h4001, 1'b1, 1'b0);
        wait_idle();

        // reset on the second CALC cycle aborts with no done
        a = 16'h1111; b = 16'h2222; sub = 1'b0; sat = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_done", {31'h0, done}, 32'd0);
        chk("abort_result", {16'h0, result}, 32'd0);
        chk("abort_carry", {31'h0, carry}, 32'd0);
        chk("abort_ovf", {31'h0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, done}, 32'd0);
        end

        issue16(16'hABCD, 16'h1234, 1'b1, 1'b0); wait_idle();

        for (int i = 0; i < 60; i++) begin
            issue16(pick16(), pick16(), 1'($urandom), 1'($urandom));
            wait_done16();
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_idle();

        issue8(8'h7F, 8'h80, 1'b0, 1'b0);
        chk("d8_busy", {31'h0, busy8}, 32'd1);
        @(negedge clk);
        chk("d8_done_next_edge", {31'h0, done8}, 32'd1);
        wait_idle();
        for (int i = 0; i < 20; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            wait_done8();
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
